// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared image pipeline parameters and streamer FSM state type
// Purpose: frame geometry, pixel/address widths and state enum shared by the adder and streamer stages.
// Ports: none (package).
package im_pkg;

   localparam int N      = 128;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 14;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } im_state_e;

   // The read counter must be able to hold N*N itself (saturated, frame fully issued).
   function automatic int cnt_width(input int n);
      return $clog2(n * n + 1);
   endfunction

endpackage

// File: rtl/im_streamer_if.sv
// rtl/im_streamer_if.sv - BRAM read port plus pixel stream bundle for im_streamer
// Purpose: groups the BRAM port (ena/wea/addr/din/dout) and the output pixel stream
//          (m_valid/m_data/m_ready/m_last).
// Ports: master = streamer side, slave = BRAM and downstream consumer side.
interface im_streamer_if #(
   parameter int PIX_W  = im_pkg::PIX_W,
   parameter int ADDR_W = im_pkg::ADDR_W
);
   logic              ena;
   logic              wea;
   logic [ADDR_W-1:0] addr;
   logic [PIX_W-1:0]  din;
   logic [PIX_W-1:0]  dout;
   logic              m_valid;
   logic [PIX_W-1:0]  m_data;
   logic              m_ready;
   logic              m_last;

   modport master (
      output ena, wea, addr, din, m_valid, m_data, m_last,
      input  dout, m_ready
   );

   modport slave (
      input  ena, wea, addr, din, m_valid, m_data, m_last,
      output dout, m_ready
   );
endinterface

// File: rtl/im_skid_fifo.sv
// rtl/im_skid_fifo.sv - 2-entry FIFO holding read pixels (data + last flag)
// Purpose: absorbs the BRAM read latency so the stream can stall without losing data.
// Ports: clk, rst_n (async active-low), push/push_data (write), pop (read, ignored when empty),
//        head (oldest entry), count (0..2).
module im_skid_fifo #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic         pop_ok;

   assign pop_ok = pop && (count_q != 2'd0);

   // Push is never gated: the read issue logic guarantees a free slot for every read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push} - {1'b0, pop_ok};
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/im_streamer.sv
// rtl/im_streamer.sv - streams an N*N frame out of BRAM in address order with valid/ready
// Purpose: on begin_streaming, reads pixels 0..N*N-1 (1-cycle BRAM latency) into a 2-entry
//          FIFO and presents them on the pixel stream, m_last on the final pixel.
// Ports: clk, rst_n (async active-low), begin_streaming (level start), busy, stream_done,
//        bus (im_streamer_if.master: BRAM read port and pixel stream).
module im_streamer #(
   parameter int N      = im_pkg::N,
   parameter int PIX_W  = im_pkg::PIX_W,
   parameter int ADDR_W = im_pkg::ADDR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          begin_streaming,
   output logic          busy,
   output logic          stream_done,
   im_streamer_if.master bus
);
   import im_pkg::*;

   localparam int               CNT_W     = cnt_width(N);
   localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(N * N);
   localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(N * N - 1);

   im_state_e        state_q;
   logic [CNT_W-1:0] rd_cnt_q;
   logic             inflight_q;
   logic             inflight_last_q;
   logic             busy_q;
   logic             done_q;

   logic [1:0]       fifo_count;
   logic [PIX_W:0]   fifo_head;
   logic             m_valid;
   logic             pop;
   logic             issue;
   logic [2:0]       pending;

   assign m_valid = (fifo_count != 2'd0);
   assign pop     = m_valid && bus.m_ready;
   assign pending = 3'(fifo_count) + 3'(inflight_q);

   // Issue only while the FIFO plus the outstanding read, less this cycle's pop, leaves a slot.
   assign issue = (state_q == STREAM) && (rd_cnt_q < FRAME_PIX) &&
                  (pending < (pop ? 3'd3 : 3'd2));

   im_skid_fifo #(
      .W (PIX_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, bus.dout}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         rd_cnt_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue && (rd_cnt_q == LAST_PIX);
         case (state_q)
            IDLE: begin
               if (begin_streaming) begin
                  state_q  <= STREAM;
                  rd_cnt_q <= '0;
                  busy_q   <= 1'b1;
               end
            end
            STREAM: begin
               if (issue) begin
                  rd_cnt_q <= rd_cnt_q + CNT_W'(1);
               end
               // begin_streaming is deliberately not looked at here: a started frame always completes.
               if (pop && fifo_head[PIX_W]) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               if (!begin_streaming) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ena     = issue;
   assign bus.wea     = 1'b0;
   assign bus.addr    = issue ? ADDR_W'(rd_cnt_q) : '0;
   assign bus.din     = '0;
   assign bus.m_valid = m_valid;
   assign bus.m_data  = fifo_head[PIX_W-1:0];
   assign bus.m_last  = m_valid && fifo_head[PIX_W];
   assign busy        = busy_q;
   assign stream_done = done_q;
endmodule

// File: tb/tb_im_streamer.sv
// tb/tb_im_streamer.sv - self-checking bench for im_streamer (N=4 frame, random BRAM contents)
module tb_im_streamer;

   localparam int TN  = 4;
   localparam int NN  = TN * TN;
   localparam int TPW = 8;
   localparam int TAW = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic begin_streaming;
   logic busy;
   logic stream_done;

   im_streamer_if #(.PIX_W(TPW), .ADDR_W(TAW)) bus ();

   im_streamer #(
      .N      (TN),
      .PIX_W  (TPW),
      .ADDR_W (TAW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .begin_streaming (begin_streaming),
      .busy            (busy),
      .stream_done     (stream_done),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   logic [TPW-1:0] mem [1 << TAW];

   always @(posedge clk) begin
      if (bus.ena) bus.dout <= mem[bus.addr];
   end

   int checks = 0;
   int errors = 0;

   // Reference model state: the frame is simply mem[0..NN-1] in order.
   int             xfers;
   int             reads;
   int             last_count;
   logic           prev_stall;
   logic [TPW-1:0] prev_data;
   logic           prev_last;

   typedef struct {
      logic           rdy;
      logic           ena;
      logic [TAW-1:0] addr;
      logic           valid;
      int             idx;
      logic           busy;
      logic           done;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   // Every negedge goes through here so the stream model sees every cycle.
   task automatic neg();
      @(negedge clk);
      if (!rst_n) begin
         xfers      = 0;
         reads      = 0;
         prev_stall = 1'b0;
      end else begin
         if (bus.ena) begin
            check("rd_addr_order", 32'(bus.addr), 32'(reads));
            check("rd_addr_range", 32'(int'(bus.addr) < NN), 32'd1);
            reads++;
         end
         check("wea_din_zero", 32'({bus.wea, bus.din}), 32'd0);
         if (prev_stall) begin
            check("hold_valid", 32'(bus.m_valid), 32'd1);
            check("hold_data", 32'(bus.m_data), 32'(prev_data));
            check("hold_last", 32'(bus.m_last), 32'(prev_last));
         end
         if (bus.m_valid) begin
            if (xfers >= NN) begin
               check("extra_pixel", 32'(xfers), 32'(NN - 1));
            end else begin
               check("pix_data", 32'(bus.m_data), 32'(mem[xfers]));
               check("pix_last", 32'(bus.m_last), 32'(xfers == NN - 1));
            end
         end else begin
            check("last_without_valid", 32'(bus.m_last), 32'd0);
         end
         if (bus.m_valid && bus.m_ready) xfers++;
         check("occupancy", 32'((reads - xfers) <= 2), 32'd1);
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
         if (!busy && !bus.ena && !bus.m_valid) begin
            if (xfers != 0) last_count = xfers;
            xfers = 0;
            reads = 0;
         end
      end
   endtask

   task automatic check_idle(input string tag, input bit with_data);
      check({tag, "_ena"}, 32'(bus.ena), 32'd0);
      check({tag, "_addr"}, 32'(bus.addr), 32'd0);
      check({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
      check({tag, "_last"}, 32'(bus.m_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(stream_done), 32'd0);
      if (with_data) check({tag, "_data"}, 32'(bus.m_data), 32'd0);
   endtask

   // Called at a posedge; returns just after the start edge E0.
   task automatic start_frame();
      last_count = 0;
      #1 begin_streaming = 1'b1;
      neg();
      check("start_idle_ena", 32'(bus.ena), 32'd0);
      check("start_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
   endtask

   // mode 0: ready held 1, mode 1: ready toggles, mode 2: random ready.
   task automatic run_frame(input int mode, input int drop_at, input int k0, input int budget,
                            output int k_done);
      k_done = -1;
      for (int k = k0; k < k0 + budget; k++) begin
         #1;
         case (mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = (k % 2 == 0);
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         if (drop_at >= 0 && xfers >= drop_at) begin_streaming = 1'b0;
         neg();
         if (stream_done) begin
            k_done = k;
            break;
         end
         @(posedge clk);
      end
      check("done_seen", 32'(k_done >= 0), 32'd1);
   endtask

   // Called at the negedge where stream_done was first seen; returns at a posedge in IDLE.
   task automatic end_frame(input string tag);
      check({tag, "_count"}, 32'(last_count), 32'(NN));
      check({tag, "_busy_clear"}, 32'(busy), 32'd0);
      @(posedge clk);
      if (begin_streaming) begin
         for (int i = 0; i < 3; i++) begin
            neg();
            check({tag, "_done_hold"}, 32'(stream_done), 32'd1);
            @(posedge clk);
         end
         #1 begin_streaming = 1'b0;
         neg();
         check({tag, "_done_until_edge"}, 32'(stream_done), 32'd1);
         @(posedge clk);
      end
      neg();
      check({tag, "_done_clear"}, 32'(stream_done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      @(posedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int kd;
      int kv;
      for (int i = 0; i < (1 << TAW); i++) mem[i] = 8'($urandom_range(0, 255));
      // {ready, ena, addr, m_valid, pixel index (-1 none), busy, stream_done}, cycle k after start edge
      tbl[0]  = '{1'b1, 1'b1, 5'd0, 1'b0, -1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 5'd1, 1'b0, -1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 5'd2, 1'b1,  0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 5'd3, 1'b1,  1, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 5'd4, 1'b1,  2, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 5'd5, 1'b1,  3, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b1,  4, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 5'd0, 1'b1,  4, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 5'd6, 1'b1,  4, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 5'd7, 1'b1,  5, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 5'd8, 1'b1,  6, 1'b1, 1'b0};

      bus.m_ready     = 1'b1;
      begin_streaming = 1'b0;
      rst_n           = 1'b0;
      last_count      = 0;
      neg();
      check_idle("reset", 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      neg();
      check_idle("idle", 1'b1);
      @(posedge clk);

      // Start-up latency and a 2-cycle stall, vector table
      start_frame();
      for (int k = 0; k < 11; k++) begin
         #1 bus.m_ready = tbl[k].rdy;
         neg();
         check($sformatf("tbl%0d_ena", k), 32'(bus.ena), 32'(tbl[k].ena));
         check($sformatf("tbl%0d_addr", k), 32'(bus.addr), 32'(tbl[k].addr));
         check($sformatf("tbl%0d_valid", k), 32'(bus.m_valid), 32'(tbl[k].valid));
         if (tbl[k].idx >= 0)
            check($sformatf("tbl%0d_data", k), 32'(bus.m_data), 32'(mem[tbl[k].idx]));
         check($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
         check($sformatf("tbl%0d_done", k), 32'(stream_done), 32'(tbl[k].done));
         @(posedge clk);
      end
      run_frame(0, -1, 11, 100, kd);
      check("tbl_done_cycle", 32'(kd), 32'(NN + 4));
      end_frame("f_tbl");

      // Full throughput: done exactly N*N+2 cycles after the start edge
      start_frame();
      run_frame(0, -1, 0, 100, kd);
      check("full_done_cycle", 32'(kd), 32'(NN + 2));
      end_frame("f_full");

      // Long stall from the first valid pixel
      bus.m_ready = 1'b0;
      start_frame();
      kv = -1;
      for (int k = 0; k < 52; k++) begin
         #1 bus.m_ready = 1'b0;
         neg();
         if (bus.m_valid && kv < 0) kv = k;
         if (k == 51) begin
            check("stall_reads", 32'(reads), 32'd2);
            check("stall_valid", 32'(bus.m_valid), 32'd1);
            check("stall_data", 32'(bus.m_data), 32'(mem[0]));
         end
         @(posedge clk);
      end
      check("first_valid_cycle", 32'(kv), 32'd2);
      run_frame(0, -1, 52, 100, kd);
      check("stall_done_cycle", 32'(kd), 32'd68);
      end_frame("f_stall");

      // Asynchronous reset mid-frame
      bus.m_ready = 1'b1;
      start_frame();
      for (int k = 0; k < 100; k++) begin
         #1;
         neg();
         @(posedge clk);
         if (xfers >= 7) break;
      end
      check("pre_reset_xfers", 32'(xfers), 32'd7);
      #2 rst_n = 1'b0;
      begin_streaming = 1'b0;
      #1 check_idle("async_rst", 1'b1);
      neg();
      @(posedge clk);
      neg();
      @(posedge clk);
      #1 rst_n = 1'b1;
      neg();
      check_idle("post_rst", 1'b1);
      @(posedge clk);

      // Toggling and random ready, begin_streaming sometimes dropped mid-frame
      for (int f = 0; f < 8; f++) begin
         int drop;
         drop = (f % 2 == 0) ? int'($urandom_range(0, NN - 1)) : -1;
         start_frame();
         run_frame((f == 0) ? 1 : 2, drop, 0, 400, kd);
         end_frame($sformatf("f_rand%0d", f));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/im_streamer.md
IM_STREAMER -- requirements
Module: im_streamer

Interface
REQ-001 Parameter N, default 128, image side length in pixels; frame = N*N pixels.
REQ-002 Parameter PIX_W, default 8, pixel width in bits.
REQ-003 Parameter ADDR_W, default 14, BRAM address width; SHALL satisfy 2^ADDR_W >= N*N.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 begin_streaming  input  1  level start request, driven by upstream adder_done.
REQ-007 ena  output  1  BRAM port enable.
REQ-008 wea  output  1  BRAM write enable, constant 0.
REQ-009 addr  output  ADDR_W  BRAM read address.
REQ-010 din  output  PIX_W  BRAM write data, constant 0.
REQ-011 dout  input  PIX_W  BRAM read data, valid 1 cycle after ena=1 with addr.
REQ-012 m_valid  output  1  output pixel valid.
REQ-013 m_data  output  PIX_W  output pixel.
REQ-014 m_ready  input  1  downstream accept; transfer when m_valid & m_ready.
REQ-015 m_last  output  1  high with final pixel (index N*N-1) of the frame.
REQ-016 busy  output  1  high from start until the last transfer.
REQ-017 stream_done  output  1  frame fully transferred.

Function
REQ-018 FSM states: IDLE, STREAM, DONE.
REQ-019 IDLE -> STREAM when begin_streaming=1; read counter cleared to 0, busy set next cycle.
REQ-020 In STREAM a read SHALL be issued (ena=1, addr=read counter, counter+1) in any cycle where counter < N*N and (FIFO occupancy + reads in flight - pop this cycle) < 2.
REQ-021 Read data SHALL be written into a 2-entry FIFO the cycle after issue; no read data ever dropped.
REQ-022 m_valid = FIFO non-empty; m_data = FIFO head; m_data/m_last SHALL stay stable while m_valid & !m_ready.
REQ-023 Pixels SHALL be output in address order 0..N*N-1, unmodified.
REQ-024 First m_valid SHALL appear 2 cycles after the IDLE->STREAM transition (read issue + FIFO write).
REQ-025 With m_ready held 1, throughput SHALL be 1 pixel per cycle; full frame completes in N*N+2 cycles after start.
REQ-026 m_ready deasserted for any number of cycles: at most 2 pixels buffered, reads stall, no overrun.
REQ-027 Read counter SHALL saturate at N*N; no read issued beyond address N*N-1 (no wrap).
REQ-028 STREAM -> DONE on the cycle of the last transfer (m_last & m_valid & m_ready); busy cleared, stream_done set next cycle.
REQ-029 DONE holds stream_done=1 while begin_streaming=1; DONE -> IDLE when begin_streaming=0, stream_done cleared.
REQ-030 begin_streaming dropping during STREAM SHALL be ignored; frame completes.
REQ-031 ena=0 whenever no read is issued; wea and din constant 0.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, counter 0, FIFO empty, in-flight read discarded, ena/m_valid/m_last/busy/stream_done=0, addr=0, m_data=0.
REQ-033 Reset mid-frame aborts the frame; after release, a new start restarts at address 0.

Structure
REQ-034 Shared package im_pkg SHALL hold N, PIX_W, ADDR_W and the FSM state enum, shared with the adder stage.
REQ-035 One sub-module im_skid_fifo (2-entry, PIX_W+1 wide for data+last, push/pop/count) SHALL hold the buffering; FSM and read issue stay in im_streamer.

Verification
REQ-036 BRAM preloaded pixel[i]=i mod 256, m_ready=1, begin_streaming rises -> 16384 transfers, data i mod 256, m_last only on index 16383, stream_done at cycle start+16386.
REQ-037 m_ready toggling 1/0 every cycle -> identical data sequence, 16384 transfers, FIFO occupancy never >2, no duplicates/gaps.
REQ-038 m_ready held 0 for 50 cycles after first m_valid -> m_data=0 stable, at most 2 reads issued, then resume with pixel 1 next.
REQ-039 rst_n pulsed low at transfer 1000 -> all outputs 0 same cycle; restart -> first pixel is address 0.
REQ-040 begin_streaming dropped at transfer 500 -> frame still completes; stream_done=0 immediately after (DONE->IDLE), second start streams again from 0.
REQ-041 N=4 parameterization -> exactly 16 transfers, m_last on 16th, addr never exceeds 15.
